// File: rtl/asmd_mult_arbiter.sv
// Round-robin arbiter sharing one asmd_multiplier between NUM_REQ requesters.
// Sequences the multiplier start/ready handshake and aborts through a watchdog if the multiplier never completes.
module asmd_mult_arbiter #(
    parameter int word_length = 8,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*word_length-1:0] req_word0,
    input  logic [NUM_REQ*word_length-1:0] req_word1,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic [2*word_length-1:0]       result,
    output logic                           err,
    output logic                           mult_start,
    output logic [word_length-1:0]         mult_word0,
    output logic [word_length-1:0]         mult_word1,
    input  logic                           mult_ready,
    input  logic [2*word_length-1:0]       mult_product
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic [2*word_length-1:0] result_q, result_d;
    logic                     err_q, err_d;
    logic                     start_q, start_d;
    logic [word_length-1:0]   word0_q, word0_d;
    logic [word_length-1:0]   word1_q, word1_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     found;
    logic [PTR_W-1:0]         winner;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin : arbScan
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        err_d    = err_q;
        start_d  = 1'b0;
        word0_d  = word0_q;
        word1_d  = word1_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    grant_d = NUM_REQ'(1) << winner;
                    word0_d = req_word0[winner*word_length +: word_length];
                    word1_d = req_word1[winner*word_length +: word_length];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mult_ready) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                cnt_d = cnt_q + 1'b1;
                // Completion only ever happens in WAIT_HIGH, so the watchdog alone decides here.
                if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = grant_q;
                    state_d  = RESP;
                end else if (!mult_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (mult_ready) begin
                    result_d = mult_product;
                    err_d    = 1'b0;
                    done_d   = grant_q;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = grant_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            word0_q  <= '0;
            word1_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            start_q  <= start_d;
            word0_q  <= word0_d;
            word1_q  <= word1_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert ($onehot0(grant_q));
            assert ((done_q & ~grant_q) == '0);
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;
    assign mult_start = start_q;
    assign mult_word0 = word0_q;
    assign mult_word1 = word1_q;

endmodule
